// File: rtl/vec_pkg.sv
// ---------------------------------------------------------------------------
// vec_pkg
// Shared definitions for the vector arithmetic family (vec_pack and the
// future unpacker).
// Contents:
//   vec_state_e  - packer state: FILL (collecting lanes) / HOLD (presenting)
//   VEC_N_DEF    - default elements per vector
//   VEC_DW_DEF   - default element width
//   vec_cw()     - lane-counter width for N lanes (never below 1 bit)
// ---------------------------------------------------------------------------
package vec_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } vec_state_e;

    localparam int VEC_N_DEF  = 8;
    localparam int VEC_DW_DEF = 16;

    function automatic int vec_cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vec_lane_ctr.sv
// ---------------------------------------------------------------------------
// vec_lane_ctr
// Lane index counter for serial<->parallel vector converters.
// Priority: load-1 > clear > increment. Increment wraps N-1 -> 0.
// Ports:
//   i_clk    - clock
//   i_rst_n  - asynchronous active-low reset (count -> 0)
//   i_inc    - advance to next lane
//   i_clr    - return to lane 0
//   i_load1  - jump to lane 1 (lane 0 was filled in the same cycle)
//   o_count  - current lane index
// ---------------------------------------------------------------------------
module vec_lane_ctr
    import vec_pkg::*;
#(
    parameter  int N  = VEC_N_DEF,
    localparam int CW = vec_cw(N)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_inc,
    input  logic          i_clr,
    input  logic          i_load1,
    output logic [CW-1:0] o_count
);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load1) begin
            r_count <= CW'(1);
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= (r_count == CW'(N - 1)) ? '0 : r_count + CW'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/vec_pack.sv
// ---------------------------------------------------------------------------
// vec_pack
// Serial-to-parallel packer feeding the dotprod summation stage. Collects N
// DW-bit elements from a valid/ready stream into lanes (k-th element -> lane
// k, lane 0 least significant) and presents the vector on a registered
// valid/ready output. Back-to-back vectors flow without bubbles.
// Optional feature macro: VEC_PACK_LAST_EN (adds in_last / out_len for short
// vectors; unused lanes read 0).
// Ports:
//   clk        - clock
//   nreset     - asynchronous active-low reset
//   in_valid   - element on in_data is valid
//   in_ready   - element can be accepted this cycle
//   in_data    - element value
//   in_last    - (VEC_PACK_LAST_EN) element closes a short vector
//   out_valid  - out_data holds a complete vector
//   out_ready  - downstream accepts the vector
//   out_data   - packed vector, lane i = out_data[i*DW +: DW]
//   out_len    - (VEC_PACK_LAST_EN) number of valid lanes, 1..N
// ---------------------------------------------------------------------------
module vec_pack
    import vec_pkg::*;
#(
    parameter  int N  = VEC_N_DEF,
    parameter  int DW = VEC_DW_DEF,
    localparam int CW = vec_cw(N)
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
`ifdef VEC_PACK_LAST_EN
    input  logic            in_last,
    output logic [CW:0]     out_len,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*DW-1:0] out_data
);

    vec_state_e    r_state;
    logic          r_out_valid;
    logic [DW-1:0] r_lanes [N];
`ifdef VEC_PACK_LAST_EN
    logic [CW:0]   r_len;
`endif

    logic [CW-1:0] w_count;
    logic          w_in_fire;
    logic          w_out_fire;
    logic          w_last_beat;
    logic          w_close;
    logic          w_ctr_inc;
    logic          w_ctr_clr;
    logic          w_ctr_load1;

    // While holding, a new element may only enter in the cycle the held
    // vector leaves, so the input is gated straight by out_ready.
    assign in_ready   = (r_state == FILL) ? 1'b1 : out_ready;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = r_out_valid & out_ready;

`ifdef VEC_PACK_LAST_EN
    assign w_last_beat = in_last;
`else
    assign w_last_beat = 1'b0;
`endif

    assign w_close = (w_count == CW'(N - 1)) | w_last_beat;

    always_comb begin
        w_ctr_inc   = 1'b0;
        w_ctr_clr   = 1'b0;
        w_ctr_load1 = 1'b0;
        if (r_state == FILL) begin
            if (w_in_fire) begin
                if (w_close) w_ctr_clr = 1'b1;
                else         w_ctr_inc = 1'b1;
            end
        end else if (w_out_fire) begin
            // Overlapping beat fills lane 0, so counting resumes at lane 1.
            if (w_in_fire && !w_last_beat) w_ctr_load1 = 1'b1;
            else                           w_ctr_clr   = 1'b1;
        end
    end

    vec_lane_ctr #(.N(N)) u_lane_ctr (
        .i_clk   (clk),
        .i_rst_n (nreset),
        .i_inc   (w_ctr_inc),
        .i_clr   (w_ctr_clr),
        .i_load1 (w_ctr_load1),
        .o_count (w_count)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state     <= FILL;
            r_out_valid <= 1'b0;
            for (int i = 0; i < N; i++) r_lanes[i] <= '0;
`ifdef VEC_PACK_LAST_EN
            r_len       <= '0;
`endif
        end else begin
            case (r_state)
                FILL: begin
                    if (w_in_fire) begin
                        r_lanes[w_count] <= in_data;
                        if (w_close) begin
                            r_state     <= HOLD;
                            r_out_valid <= 1'b1;
`ifdef VEC_PACK_LAST_EN
                            r_len       <= (CW+1)'(w_count) + (CW+1)'(1);
`endif
                        end
                    end
                end
                HOLD: begin
                    if (w_out_fire) begin
                        // Lanes are cleared on release so short vectors read
                        // zero in their unused lanes.
                        for (int i = 0; i < N; i++) r_lanes[i] <= '0;
                        if (w_in_fire) r_lanes[0] <= in_data;
                        if (w_in_fire && w_last_beat) begin
                            // One-element vector closes immediately: stay
                            // presenting with the new contents.
`ifdef VEC_PACK_LAST_EN
                            r_len <= (CW+1)'(1);
`endif
                        end else begin
                            r_state     <= FILL;
                            r_out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= FILL;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_out
        assign out_data[gi*DW +: DW] = r_lanes[gi];
    end

    assign out_valid = r_out_valid;
`ifdef VEC_PACK_LAST_EN
    assign out_len   = r_len;
`endif

endmodule

// File: doc/vec_pack.md
Name: vec_pack

Overview:
- Serial-to-parallel packer that sits directly upstream of the `dotprod` summation stage.
- Accepts one DW-bit element per cycle over a valid/ready stream and assembles N elements into the concatenated vector `a[N*DW-1:0]` that the sum stage consumes.
- Presents each completed vector on a registered valid/ready output.
- Zero bubbles between back-to-back vectors when downstream is ready.

Parameters:
- N, 8, elements per vector; legal range N >= 2.
- DW, 16, bitwidth of each element.
- CW, $clog2(N), lane counter width (localparam, not overridable).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- nreset  input  1  asynchronous active-low reset.
- in_valid  input  1  element on in_data is valid.
- in_ready  output  1  block can accept an element this cycle.
- in_data  input  DW  element value.
- out_valid  output  1  out_data holds a complete vector.
- out_ready  input  1  downstream accepts the vector.
- out_data  output  N*DW  packed vector; lane i = out_data[i*DW +: DW].

Behaviour:
- Reset: the clock is single; reset is asynchronous and active-low (nreset). While nreset=0 and on release: out_valid=0, out_data=0, lane counter=0, state=FILL. in_ready=1 in the first cycle after release.
- Handshakes: an input beat transfers on in_valid & in_ready; an output transfers on out_valid & out_ready.
- Lane order: the k-th accepted element of a vector (k=0..N-1) lands in lane k, bits [k*DW +: DW]. Element 0 is least significant.
- State FILL:
  - out_valid=0, in_ready=1.
  - Each accepted beat writes lane[count] and increments count.
  - Accepting lane N-1: count wraps to 0, next state is HOLD, out_valid=1 in the following cycle.
  - Latency: last element accepted in cycle t → out_valid=1 in cycle t+1.
- State HOLD:
  - out_valid=1, out_data frozen while out_ready=0. No lane may change.
  - in_ready = out_ready (combinational).
  - On output transfer without an input beat: go to FILL, out_valid=0, all lanes cleared to 0, count=0.
  - On output transfer with a simultaneous input beat: clear lanes, write the new element into lane 0, set count=1, go to FILL. No lost beat and no bubble.
- in_valid may drop between beats of a vector; partial contents are held indefinitely.
- Downstream sum width is DW+$clog2(N). The packer performs no arithmetic and passes elements unmodified.
- Reset asserted mid-vector discards the partial vector and any pending output immediately (asynchronous).
- X on in_data when in_valid=0 must not propagate into lanes.

Optional Feature:
- Macro: VEC_PACK_LAST_EN.
- Enabled, the following ports are added:
  - in_last  input  1  final element of a short vector.
  - out_len  output  CW+1  number of valid lanes, range 1..N.
- Accepting a beat with in_last=1 at count k closes the vector: lanes k+1..N-1 read 0, out_len=k+1, and HOLD is entered exactly as for a full vector.
- in_last on lane N-1 is equivalent to a normal close.
- out_len resets to 0.
- Disabled: the in_last and out_len ports are absent; every vector is exactly N lanes.

Decomposition:
- Shared package vec_pkg:
  - state enum {FILL, HOLD}.
  - Default N/DW constants for the arithmetic family.
  - Width helper for lane-count (CW).
- One natural sub-module, vec_lane_ctr: lane counter with wrap/clear/load-1, reused by the future unpacker.
- Lane register array and handshake stay in vec_pack.

Test Plan:
- Reset then 8 consecutive beats 1..8 (N=8, DW=16), out_ready=1 → out_valid one cycle after beat 8; out_data=0x0008_0007_0006_0005_0004_0003_0002_0001; downstream sum=36.
- Backpressure: full vector 0xFFFF×8, out_ready=0 for 5 cycles, in_valid held 1 with 0x0001 → in_ready=0 for all 5 cycles, out_data stable; release → next vector starts with lane 0=0x0001 in the same cycle.
- Continuous stream of 24 beats with out_ready=1 → three vectors on cycles 9, 17, 25; in_ready never 0; no dropped or duplicated element.
- Gapped input (in_valid toggling 1,0,0,1...) for a full vector → correct lane order, single out_valid pulse after the 8th accepted beat.
- Assert nreset after beat 5, release, send 8 beats 0x10..0x17 → output lanes contain only 0x10..0x17; out_valid=0 throughout reset.
- VEC_PACK_LAST_EN: beats 0xA,0xB,0xC with in_last on the third → out_len=3, lanes 3..7=0, sum=0x21. Next vector fills from lane 0.
